// File: rtl/stonyman_ctrl.sv
// Stonyman imager sequencer: programs chip registers 2..7 via resp/incp/resv/incv
// pulse trains, then scans the frame with an ADC start/done handshake per pixel.
// Optional STONYMAN_INPHI_EN: one inphi pulse before every pixel sample.
module stonyman_ctrl #(
   parameter int ROWS          = 112,
   parameter int COLS          = 112,
   parameter int PULSE_CYCLES  = 1,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_capture_start,
   input  logic       adc_capture_done,
   input  logic [7:0] vsw_value,
   input  logic [7:0] hsw_value,
   input  logic [5:0] vref_value,
   input  logic [5:0] config_value,
   input  logic [5:0] nbias_value,
   input  logic [5:0] aobias_value,
   input  logic       capture_pixel,
   output logic       frame_capture_done,
   output logic       adc_capture_start,
   output logic       resp,
   output logic       incp,
   output logic       resv,
   output logic       incv,
   output logic       inphi,
   output logic [6:0] pixel_row,
   output logic [6:0] pixel_col
);

   typedef enum logic [3:0] {
      S_INIT, S_REGW, S_IDLE, S_SCAN, S_ROW, S_SETTLE,
      S_SAMPLE, S_WAIT_ADC, S_COL_NEXT, S_ROW_END
   } state_t;
   typedef enum logic [1:0] {PH_RISE, PH_HI, PH_LO} ph_t;

   localparam logic [4:0]  M_RESP   = 5'b00001;
   localparam logic [4:0]  M_INCP   = 5'b00010;
   localparam logic [4:0]  M_RESV   = 5'b00100;
   localparam logic [4:0]  M_INCV   = 5'b01000;
`ifdef STONYMAN_INPHI_EN
   localparam logic [4:0]  M_INPHI  = 5'b10000;
`endif
   localparam logic [15:0] P_LAST   = 16'(PULSE_CYCLES - 1);
   localparam logic [15:0] S_LAST   = 16'(SETTLE_CYCLES - 1);
   localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
   localparam logic [6:0]  ROW_LAST = 7'(ROWS - 1);

   state_t      state;
   ph_t         ph;
   logic [2:0]  sub, reg_idx;
   logic [15:0] tmr, wcnt;
   logic [4:0]  tr_mask, pins;
   logic [7:0]  tr_cnt, cur_val;
   logic        scan_pend;
   logic [6:0]  row, col;
   logic [7:0]  vsw_q, hsw_q;
   logic [5:0]  vref_q, config_q, nbias_q, aobias_q;

   assign {inphi, incv, resv, incp, resp} = pins;

   always_comb begin
      cur_val = 8'd0;
      case (reg_idx)
         3'd2: cur_val = vsw_q;
         3'd3: cur_val = hsw_q;
         3'd4: cur_val = {2'b00, vref_q};
         3'd5: cur_val = {2'b00, config_q};
         3'd6: cur_val = {2'b00, nbias_q};
         3'd7: cur_val = {2'b00, aobias_q};
         default: cur_val = 8'd0;
      endcase
   end

   // tr_cnt != 0 means a pulse train owns the pins; the main FSM stalls until it drains.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_INIT;  ph <= PH_RISE;  sub <= '0;  reg_idx <= 3'd2;
         tmr <= '0;  wcnt <= '0;  tr_mask <= '0;  tr_cnt <= '0;  pins <= '0;
         scan_pend <= 1'b0;  row <= '0;  col <= '0;
         pixel_row <= '0;  pixel_col <= '0;
         adc_capture_start <= 1'b0;  frame_capture_done <= 1'b0;
      end else begin
         adc_capture_start  <= 1'b0;
         frame_capture_done <= 1'b0;
         if (tr_cnt != 8'd0) begin
            case (ph)
               PH_RISE: begin pins <= tr_mask; tmr <= P_LAST; ph <= PH_HI; end
               PH_HI:
                  if (tmr != 16'd0) tmr <= tmr - 16'd1;
                  else begin pins <= '0; tmr <= P_LAST; ph <= PH_LO; end
               PH_LO:
                  if (tmr != 16'd0) tmr <= tmr - 16'd1;
                  else if (tr_cnt == 8'd1) begin tr_cnt <= 8'd0; ph <= PH_RISE; end
                  else begin
                     tr_cnt <= tr_cnt - 8'd1; pins <= tr_mask; tmr <= P_LAST; ph <= PH_HI;
                  end
               default: ph <= PH_RISE;
            endcase
         end else begin
            if (state == S_INIT || (state == S_IDLE && frame_capture_start)) begin
               vsw_q <= vsw_value;  hsw_q <= hsw_value;  vref_q <= vref_value;
               config_q <= config_value;  nbias_q <= nbias_value;  aobias_q <= aobias_value;
               reg_idx <= 3'd2;  sub <= '0;
               scan_pend <= (state == S_IDLE);
               state <= S_REGW;
            end else begin
               case (state)
                  S_REGW:
                     case (sub)
                        3'd0: begin tr_mask <= M_RESP; tr_cnt <= 8'd1; sub <= 3'd1; end
                        3'd1: begin tr_mask <= M_INCP; tr_cnt <= {5'd0, reg_idx}; sub <= 3'd2; end
                        3'd2: begin tr_mask <= M_RESV; tr_cnt <= 8'd1; sub <= 3'd3; end
                        3'd3: begin tr_mask <= M_INCV; tr_cnt <= cur_val; sub <= 3'd4; end
                        default: begin
                           sub <= '0;
                           if (reg_idx == 3'd7) state <= scan_pend ? S_SCAN : S_IDLE;
                           else reg_idx <= reg_idx + 3'd1;
                        end
                     endcase
                  S_SCAN:
                     case (sub)
                        3'd0: begin tr_mask <= M_RESP; tr_cnt <= 8'd1; sub <= 3'd1; end
                        3'd1: begin tr_mask <= M_INCP; tr_cnt <= 8'd1; sub <= 3'd2; end
                        3'd2: begin tr_mask <= M_RESV; tr_cnt <= 8'd1; sub <= 3'd3; end
                        default: begin row <= '0; sub <= '0; state <= S_ROW; end
                     endcase
                  S_ROW:
                     case (sub)
                        3'd0: begin tr_mask <= M_RESP; tr_cnt <= 8'd1; sub <= 3'd1; end
                        3'd1: begin tr_mask <= M_RESV; tr_cnt <= 8'd1; sub <= 3'd2; end
                        default: begin col <= '0; sub <= '0; wcnt <= S_LAST; state <= S_SETTLE; end
                     endcase
                  S_SETTLE:
                     if (wcnt != 16'd0) wcnt <= wcnt - 16'd1;
                     else begin
`ifdef STONYMAN_INPHI_EN
                        tr_mask <= M_INPHI;  tr_cnt <= 8'd1;
`endif
                        state <= S_SAMPLE;
                     end
                  S_SAMPLE:
                     if (capture_pixel) begin
                        pixel_row <= row;  pixel_col <= col;
                        adc_capture_start <= 1'b1;
                        state <= S_WAIT_ADC;
                     end else state <= S_COL_NEXT;
                  S_WAIT_ADC:
                     if (adc_capture_done) state <= S_COL_NEXT;
                  S_COL_NEXT:
                     if (col != COL_LAST) begin
                        tr_mask <= M_INCV;  tr_cnt <= 8'd1;
                        col <= col + 7'd1;  wcnt <= S_LAST;  state <= S_SETTLE;
                     end else begin sub <= '0; state <= S_ROW_END; end
                  S_ROW_END:
                     if (row == ROW_LAST) begin
                        frame_capture_done <= 1'b1;  state <= S_IDLE;
                     end else
                        case (sub)
                           3'd0: begin tr_mask <= M_RESP; tr_cnt <= 8'd1; sub <= 3'd1; end
                           3'd1: begin tr_mask <= M_INCP; tr_cnt <= 8'd1; sub <= 3'd2; end
                           3'd2: begin tr_mask <= M_INCV; tr_cnt <= 8'd1; sub <= 3'd3; end
                           default: begin row <= row + 7'd1; sub <= '0; state <= S_ROW; end
                        endcase
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_stonyman_ctrl.sv
// Directed bench for stonyman_ctrl: behavioural chip model driven by the pulse pins,
// ADC responder with a slow pixel, and per-frame checks of counts and chip state.
module tb_stonyman_ctrl;
   localparam int R = 7, C = 9, PC = 2, SC = 2;
`ifdef STONYMAN_INPHI_EN
   localparam int PHI_PER_FRAME = R * C;
`else
   localparam int PHI_PER_FRAME = 0;
`endif

   logic clk, reset, frame_capture_start, adc_capture_done, capture_pixel;
   logic [7:0] vsw_value, hsw_value;
   logic [5:0] vref_value, config_value, nbias_value, aobias_value;
   logic frame_capture_done, adc_capture_start, resp, incp, resv, incv, inphi;
   logic [6:0] pixel_row, pixel_col;
   logic [4:0] pv;

   stonyman_ctrl #(.ROWS(R), .COLS(C), .PULSE_CYCLES(PC), .SETTLE_CYCLES(SC)) dut (
      .clk(clk), .reset(reset), .frame_capture_start(frame_capture_start),
      .adc_capture_done(adc_capture_done), .vsw_value(vsw_value), .hsw_value(hsw_value),
      .vref_value(vref_value), .config_value(config_value), .nbias_value(nbias_value),
      .aobias_value(aobias_value), .capture_pixel(capture_pixel),
      .frame_capture_done(frame_capture_done), .adc_capture_start(adc_capture_start),
      .resp(resp), .incp(incp), .resv(resv), .incv(incv), .inphi(inphi),
      .pixel_row(pixel_row), .pixel_col(pixel_col));

   assign pv = {inphi, incv, resv, incp, resp};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int ptr = 0, regs[8];
   int adc_cnt = 0, done_cnt = 0, phi_cnt = 0, edge_cnt = 0;
   int order_err = 0, width_err = 0, pix_idx = 0, hi_len[5];
   int freeze_err = 0, slow_seen = 0;
   bit slow = 1'b0;
   logic [4:0] pv_q = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // chip model plus pulse-width, pixel-order and handshake counters
   always @(negedge clk) begin
      for (int i = 0; i < 5; i++) begin
         if (pv[i] === 1'b1 && pv_q[i] !== 1'b1) begin
            edge_cnt++;
            case (i)
               0: ptr = 0;
               1: ptr = (ptr + 1) % 8;
               2: regs[ptr] = 0;
               3: regs[ptr] = regs[ptr] + 1;
               default: phi_cnt++;
            endcase
         end
         if (pv[i] === 1'b1) hi_len[i]++;
         else begin
            if (pv_q[i] === 1'b1 && reset && hi_len[i] != PC) width_err++;
            hi_len[i] = 0;
         end
      end
      pv_q = pv;
      if (!reset) pix_idx = 0;
      else if (frame_capture_done) begin done_cnt++; pix_idx = 0; end
      else if (adc_capture_start) begin
         if (pixel_row !== 7'(pix_idx / C) || pixel_col !== 7'(pix_idx % C)) order_err++;
         pix_idx++;
         adc_cnt++;
      end
   end

   // ADC: done two cycles after start, or fifty on pixel (5,7) with pins checked frozen
   initial begin
      logic [20:0] snap;
      adc_capture_done = 1'b0;
      forever begin
         @(negedge clk);
         adc_capture_done = 1'b0;
         if (adc_capture_start && reset) begin
            if (slow && pixel_row == 7'd5 && pixel_col == 7'd7) begin
               slow_seen++;
               @(negedge clk);
               snap = {pv, pixel_row, pixel_col, adc_capture_start, frame_capture_done};
               repeat (49) begin
                  @(negedge clk);
                  if (snap !== {pv, pixel_row, pixel_col, adc_capture_start, frame_capture_done})
                     freeze_err++;
               end
            end else repeat (2) @(negedge clk);
            adc_capture_done = 1'b1;
         end
      end
   end

   task automatic wait_quiet(input string tag);
      int q = 0, n = 0;
      while (q < 20 && n < 8000) begin
         @(negedge clk);
         n++;
         q = (pv === 5'd0) ? q + 1 : 0;
      end
      chk(tag, n < 8000, 1);
   endtask

   task automatic run_frame(input bit inject, input string tag);
      int n = 0, d0 = done_cnt;
      frame_capture_start = 1'b1;
      @(negedge clk);
      frame_capture_start = 1'b0;
      while (done_cnt == d0 && n < 8000) begin
         @(negedge clk);
         n++;
         frame_capture_start = inject && (n % 400 == 0);
      end
      frame_capture_start = 1'b0;
      repeat (2) @(negedge clk);
      chk(tag, done_cnt - d0, 1);
   endtask

   task automatic chk_regs(input string tag, input int a, b, c, d, e, f);
      int ev[6];
      ev = '{a, b, c, d, e, f};
      for (int i = 2; i < 8; i++) chk($sformatf("%s_reg%0d", tag, i), regs[i], ev[i-2]);
   endtask

   task automatic chk_frame_end(input string tag);
      chk({tag, "_colsel"}, regs[0], C - 1);
      chk({tag, "_rowsel"}, regs[1], R - 1);
      chk({tag, "_ptr"}, ptr, 0);
   endtask

   initial begin
      int a0, p0, d0, e0;
      for (int i = 0; i < 8; i++) regs[i] = 0;
      for (int i = 0; i < 5; i++) hi_len[i] = 0;
      reset = 1'b0;  frame_capture_start = 1'b0;  capture_pixel = 1'b1;
      vsw_value = 8'd1;  hsw_value = 8'd2;  vref_value = 6'd3;
      config_value = 6'd4;  nbias_value = 6'd5;  aobias_value = 6'd6;
      repeat (5) @(negedge clk);
      chk("rst_outputs", {11'd0, frame_capture_done, adc_capture_start, pv, pixel_row, pixel_col}, 0);
      reset = 1'b1;
      wait_quiet("init_quiet");
      chk_regs("init", 1, 2, 3, 4, 5, 6);
      chk("init_ptr", ptr, 7);
      chk("init_adc", adc_cnt, 0);
      chk("init_done", done_cnt, 0);

      // full frame with ADC handshakes
      a0 = adc_cnt;  p0 = phi_cnt;
      run_frame(1'b0, "f1_done");
      chk("f1_adc", adc_cnt - a0, R * C);
      chk("f1_order", order_err, 0);
      chk("f1_inphi", phi_cnt - p0, PHI_PER_FRAME);
      chk_frame_end("f1");
      chk_regs("f1", 1, 2, 3, 4, 5, 6);
      chk("f1_width", width_err, 0);

      // scan without ADC
      capture_pixel = 1'b0;
      a0 = adc_cnt;
      run_frame(1'b0, "f2_done");
      chk("f2_adc", adc_cnt - a0, 0);
      chk_frame_end("f2");

      // slow ADC on pixel (5,7)
      capture_pixel = 1'b1;  slow = 1'b1;
      a0 = adc_cnt;
      run_frame(1'b0, "f3_done");
      slow = 1'b0;
      chk("f3_slow_seen", slow_seen, 1);
      chk("f3_frozen", freeze_err, 0);
      chk("f3_adc", adc_cnt - a0, R * C);
      chk("f3_order", order_err, 0);
      chk_frame_end("f3");

      // reset in the middle of a scan
      d0 = done_cnt;
      frame_capture_start = 1'b1;
      @(negedge clk);
      frame_capture_start = 1'b0;
      repeat (600) @(negedge clk);
      reset = 1'b0;
      vsw_value = 8'd11;  hsw_value = 8'd12;  vref_value = 6'd13;
      config_value = 6'd14;  nbias_value = 6'd15;  aobias_value = 6'd16;
      @(negedge clk);
      chk("mid_rst_outputs", {11'd0, frame_capture_done, adc_capture_start, pv, pixel_row, pixel_col}, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      wait_quiet("mid_rst_quiet");
      chk("mid_rst_no_done", done_cnt - d0, 0);
      chk_regs("mid_rst", 11, 12, 13, 14, 15, 16);
      chk("mid_rst_ptr", ptr, 7);

      // new VSW taken at frame start; starts during the frame are ignored
      vsw_value = 8'd200;
      d0 = done_cnt;
      run_frame(1'b1, "f5_done");
      e0 = edge_cnt;
      repeat (40) @(negedge clk);
      chk("f5_no_restart", edge_cnt - e0, 0);
      chk("f5_single_done", done_cnt - d0, 1);
      chk_regs("f5", 200, 12, 13, 14, 15, 16);
      chk_frame_end("f5");
      chk("f5_width", width_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/stonyman_ctrl.md
Name: stonyman_ctrl

Overview:
Sequencer for the CentEye Stonyman imager. It programs the chip's eight on-chip registers by pulsing the pointer and value lines. It then scans a full frame pixel by pixel and hands each pixel to an external ADC block through a start/done handshake. It sits between the frame-capture software interface (MSS/APB registers) and the imager pins.

Parameters:
ROWS, 112, number of pixel rows scanned per frame (1..128)
COLS, 112, number of pixel columns scanned per frame (1..128)
PULSE_CYCLES, 1, high time and low time, in clk cycles, of every resp/incp/resv/incv/inphi pulse
SETTLE_CYCLES, 1, clk cycles waited after a column/row change before sampling

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
frame_capture_start  in  1  one-cycle request to capture a frame; honoured only in IDLE
adc_capture_done  in  1  ADC finished current pixel; level, sampled in WAIT_ADC
vsw_value  in  8  value written to chip register 2 (VSW)
hsw_value  in  8  value written to register 3 (HSW)
vref_value  in  6  value written to register 4 (VREF)
config_value  in  6  value written to register 5 (CONFIG)
nbias_value  in  6  value written to register 6 (NBIAS)
aobias_value  in  6  value written to register 7 (AOBIAS)
capture_pixel  in  1  1: sample every pixel via ADC; 0: scan without ADC handshakes
frame_capture_done  out  1  one-cycle pulse when the frame scan completes
adc_capture_start  out  1  one-cycle pulse requesting ADC conversion of the current pixel
resp  out  1  chip pointer reset pulse
incp  out  1  chip pointer increment pulse
resv  out  1  chip value reset pulse (clears register at pointer)
incv  out  1  chip value increment pulse (register at pointer +1)
inphi  out  1  chip amplifier phi pulse
pixel_row  out  7  row of the pixel being sampled
pixel_col  out  7  column of the pixel being sampled

Behaviour:
- Chip model: resp sets ptr=0. incp sets ptr=ptr+1 mod 8. resv sets reg[ptr]=0. incv sets reg[ptr]=reg[ptr]+1. Registers: 0 COLSEL, 1 ROWSEL, 2..7 as above.
- Primitive SET_PTR(p) is one resp pulse then p incp pulses. SET_VAL(v) is one resv pulse then v incv pulses. Each pulse is high PULSE_CYCLES, then low PULSE_CYCLES.
- The main state machine steps through sub_state phases of each primitive with a sub-state counter.
- Reset (reset=0 at a clk edge) sets all outputs to 0, pixel_row=pixel_col=0, main_state=INIT. Reset mid-frame aborts the frame with no done pulse.
- INIT: latch the six value inputs, then for r=2..7 do SET_PTR(r) and SET_VAL(latched value). Then go to IDLE.
- IDLE: all pins low. On frame_capture_start=1, first re-run the INIT register writes with freshly latched values, then run the scan. frame_capture_start outside IDLE is ignored.
- Scan start: SET_PTR(1), resv pulse, so row=0.
- Per row: SET_PTR(0), resv pulse, so col=0.
- Per column: wait SETTLE_CYCLES, then sample, then, if col<COLS-1, one incv pulse and col+1.
- Sample with capture_pixel=1: drive pixel_row/pixel_col with the current pixel, pulse adc_capture_start for 1 cycle, then wait in WAIT_ADC until adc_capture_done=1. There is no timeout.
- Sample with capture_pixel=0: no adc pulse; proceed immediately.
- capture_pixel is sampled per pixel.
- End of row: if row<ROWS-1, SET_PTR(1), one incv pulse, row+1, next row. Otherwise assert frame_capture_done for 1 cycle and return to IDLE.
- At frame end the chip holds COLSEL=COLS-1 and ROWSEL=ROWS-1, and ptr=0.
- pixel_row/pixel_col hold their last values between samples.
- Outputs are registered; no combinational paths from inputs to outputs.

Optional Feature:
STONYMAN_INPHI_EN. Defined: before each sample (after settle), inphi gives one pulse of PULSE_CYCLES high then PULSE_CYCLES low, then the sample proceeds. Undefined: inphi tied 0 and no extra cycles.

Test Plan:
- Reset 5 cycles low, release with values vsw=1, hsw=2, vref=3, config=4, nbias=5, aobias=6; bench chip model reaches IDLE -> reg[2..7]=1,2,3,4,5,6, ptr=7, no adc pulses, frame_capture_done=0.
- frame_capture_start pulse, capture_pixel=1, ADC responds done 2 cycles after start -> exactly 12544 adc_capture_start pulses; pixel_row/col cover all (r,c) in row-major order; one frame_capture_done pulse; model COLSEL=111, ROWSEL=111, ptr=0; reg[2..7] unchanged.
- Same frame with capture_pixel=0 -> 0 adc pulses, frame_capture_done pulses once, same final model state.
- Delay adc_capture_done 50 cycles on pixel (5,7) -> all pins frozen during wait; scan resumes after done.
- Assert reset mid-frame -> all outputs 0 next cycle, no done pulse, INIT re-writes reg[2..7].
- Change vsw_value to 200 in IDLE, then start a frame -> model reg[2]=200 after frame; frame_capture_start pulses during scan are ignored.
